// File: rtl/seq_calc_core.sv
// Sequential four-function arithmetic core: single-cycle add/subtract and
// iterative (one bit per clock) shift-add multiply and restoring divide.
module seq_calc_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 neg,
    output logic                 div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] OpMul = 2'd0;
    localparam logic [1:0] OpDiv = 2'd1;
    localparam logic [1:0] OpSub = 2'd2;
    localparam logic [1:0] OpAdd = 2'd3;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e               state_q;
    logic [1:0]           op_q;
    // Multiplicand (shifts left) or dividend/quotient (shifts left, quotient enters at LSB).
    logic [2*WIDTH-1:0]   opa_q;
    // Multiplier (shifts right) or constant divisor.
    logic [WIDTH-1:0]     opb_q;
    // Product accumulator, or partial remainder in the low WIDTH bits.
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        count_q;

    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [WIDTH-1:0]     div_rem;
    logic [WIDTH-1:0]     div_quo;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;

    always_comb begin
        mul_acc   = opb_q[0] ? (acc_q + opa_q) : acc_q;
        div_shift = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // Only taken when div_shift >= divisor, so the difference fits in WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - opb_q;
        div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_quo   = {opa_q[WIDTH-2:0], div_ge};
        sum       = {1'b0, opa_q[WIDTH-1:0]} + {1'b0, opb_q};
        diff      = {1'b0, opa_q[WIDTH-1:0]} - {1'b0, opb_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            neg         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q        <= op;
                        opa_q       <= {{WIDTH{1'b0}}, a};
                        opb_q       <= b;
                        acc_q       <= '0;
                        count_q     <= CW'(WIDTH - 1);
                        remainder   <= '0;
                        neg         <= 1'b0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StCalc;
                    end
                end

                StCalc: begin
                    unique case (op_q)
                        OpAdd: begin
                            result  <= {{(WIDTH-1){1'b0}}, sum};
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end
                        OpSub: begin
                            result  <= {{(WIDTH-1){diff[WIDTH]}}, diff};
                            neg     <= diff[WIDTH];
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end
                        OpMul: begin
                            acc_q   <= mul_acc;
                            opa_q   <= opa_q << 1;
                            opb_q   <= opb_q >> 1;
                            count_q <= count_q - 1'b1;
                            if (count_q == '0) begin
                                result  <= mul_acc;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_q <= StFin;
                            end
                        end
                        OpDiv: begin
                            if (opb_q == '0) begin
                                result      <= '1;
                                remainder   <= opa_q[WIDTH-1:0];
                                div_by_zero <= 1'b1;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state_q     <= StFin;
                            end else begin
                                acc_q   <= {{WIDTH{1'b0}}, div_rem};
                                opa_q   <= {{WIDTH{1'b0}}, div_quo};
                                count_q <= count_q - 1'b1;
                                if (count_q == '0) begin
                                    result    <= {{WIDTH{1'b0}}, div_quo};
                                    remainder <= div_rem;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    state_q   <= StFin;
                                end
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end

                StFin: state_q <= StIdle;

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_core.sv
// Directed self-checking bench for seq_calc_core at WIDTH=8 and WIDTH=16.
module tb_seq_calc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset8, start8, busy8, done8, neg8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, rem8;
    logic [15:0] result8;

    logic        reset16, start16, busy16, done16, neg16, dbz16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, rem16;
    logic [31:0] result16;

    seq_calc_core #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .remainder(rem8),
        .neg(neg8), .div_by_zero(dbz8)
    );

    seq_calc_core #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .remainder(rem16),
        .neg(neg16), .div_by_zero(dbz16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] prev8  = '0;
    logic [31:0] prev16 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [15:0] exp_res,
                        input logic [7:0] exp_rem, input logic exp_neg, input logic exp_dbz);
        int lat;
        int nbusy;
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = ~a; b8 = ~b; op8 = ~op;
        check({tag, "_hold"}, result8, prev8);
        lat = 1; nbusy = 0;
        while (!done8 && lat < 200) begin
            if (busy8) nbusy++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busycyc"}, nbusy, exp_lat - 1);
        check({tag, "_busy_at_done"}, busy8, 1'b0);
        check({tag, "_result"}, result8, exp_res);
        check({tag, "_rem"}, rem8, exp_rem);
        check({tag, "_neg"}, neg8, exp_neg);
        check({tag, "_dbz"}, dbz8, exp_dbz);
        prev8 = exp_res;
        tick();
        check({tag, "_done_pulse"}, done8, 1'b0);
        check({tag, "_result_kept"}, result8, exp_res);
    endtask

    task automatic run16(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int exp_lat, input logic [31:0] exp_res,
                         input logic [15:0] exp_rem, input logic exp_dbz);
        int lat;
        op16 = op; a16 = a; b16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0; a16 = ~a; b16 = ~b;
        check({tag, "_hold"}, result16, prev16);
        lat = 1;
        while (!done16 && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_result"}, result16, exp_res);
        check({tag, "_rem"}, rem16, exp_rem);
        check({tag, "_dbz"}, dbz16, exp_dbz);
        prev16 = exp_res;
        tick();
        check({tag, "_done_pulse"}, done16, 1'b0);
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        int seen;

        reset8 = 1'b1; start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
        reset16 = 1'b1; start16 = 1'b0; op16 = 2'd0; a16 = '0; b16 = '0;
        tick();
        tick();
        reset8 = 1'b0; reset16 = 1'b0;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_result", result8, 16'h0000);
        check("rst_rem", rem8, 8'h00);
        check("rst_neg", neg8, 1'b0);
        check("rst_dbz", dbz8, 1'b0);
        check("rst16_result", result16, 32'h0);

        // WIDTH=8 directed vectors
        run8("add_200_100", 2'd3, 8'd200, 8'd100, 2, 16'h012C, 8'd0, 1'b0, 1'b0);
        run8("add_255_255", 2'd3, 8'd255, 8'd255, 2, 16'h01FE, 8'd0, 1'b0, 1'b0);
        run8("sub_5_9", 2'd2, 8'd5, 8'd9, 2, 16'hFFFC, 8'd0, 1'b1, 1'b0);
        run8("sub_9_5", 2'd2, 8'd9, 8'd5, 2, 16'h0004, 8'd0, 1'b0, 1'b0);
        run8("sub_0_255", 2'd2, 8'd0, 8'd255, 2, 16'hFF01, 8'd0, 1'b1, 1'b0);
        run8("sub_5_5", 2'd2, 8'd5, 8'd5, 2, 16'h0000, 8'd0, 1'b0, 1'b0);
        run8("mul_255_255", 2'd0, 8'd255, 8'd255, 9, 16'hFE01, 8'd0, 1'b0, 1'b0);
        run8("mul_0_77", 2'd0, 8'd0, 8'd77, 9, 16'h0000, 8'd0, 1'b0, 1'b0);
        run8("mul_13_11", 2'd0, 8'd13, 8'd11, 9, 16'd143, 8'd0, 1'b0, 1'b0);
        run8("div_200_7", 2'd1, 8'd200, 8'd7, 9, 16'd28, 8'd4, 1'b0, 1'b0);
        run8("div_7_200", 2'd1, 8'd7, 8'd200, 9, 16'd0, 8'd7, 1'b0, 1'b0);
        run8("div_255_1", 2'd1, 8'd255, 8'd1, 9, 16'd255, 8'd0, 1'b0, 1'b0);
        run8("div_13_0", 2'd1, 8'd13, 8'd0, 2, 16'hFFFF, 8'd13, 1'b0, 1'b1);

        // start pulsed mid-multiply must be ignored
        op8 = 2'd0; a8 = 8'd12; b8 = 8'd11; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 1;
        repeat (3) begin tick(); cyc++; end
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        tick(); cyc++;
        start8 = 1'b0;
        while (!done8 && cyc < 200) begin tick(); cyc++; end
        check("ignore_lat", cyc, 9);
        check("ignore_result", result8, 16'd132);
        tick();
        check("ignore_idle1", busy8, 1'b0);
        tick();
        check("ignore_idle2", busy8, 1'b0);
        prev8 = 16'd132;

        // start held high: relaunch in the cycle after done with current operands,
        // so done pulses are WIDTH+2 cycles apart
        op8 = 2'd0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        tick();
        cyc = 1;
        a8 = 8'd5; b8 = 8'd6;
        while (!done8 && cyc < 200) begin tick(); cyc++; end
        d1 = cyc;
        check("held_first_result", result8, 16'd12);
        tick(); cyc++;
        while (!done8 && cyc < 400) begin tick(); cyc++; end
        d2 = cyc;
        start8 = 1'b0;
        check("held_first_lat", d1, 9);
        check("held_spacing", d2 - d1, 10);
        check("held_second_result", result8, 16'd30);
        tick();
        tick();
        check("held_stops", busy8, 1'b0);
        prev8 = 16'd30;

        // synchronous reset in the middle of a divide
        op8 = 2'd1; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        tick();
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_result", result8, 16'h0000);
        check("abort_rem", rem8, 8'h00);
        check("abort_neg", neg8, 1'b0);
        check("abort_dbz", dbz8, 1'b0);
        seen = 0;
        repeat (12) begin
            if (done8 || busy8) seen++;
            tick();
        end
        check("abort_no_done", seen, 0);
        prev8 = 16'h0000;
        run8("post_abort_add", 2'd3, 8'd1, 8'd2, 2, 16'd3, 8'd0, 1'b0, 1'b0);

        // WIDTH=16 rerun
        run16("w16_add", 2'd3, 16'd200, 16'd100, 2, 32'h0000_012C, 16'd0, 1'b0);
        run16("w16_add_carry", 2'd3, 16'hFFFF, 16'd1, 2, 32'h0001_0000, 16'd0, 1'b0);
        run16("w16_mul", 2'd0, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 16'd0, 1'b0);
        run16("w16_div", 2'd1, 16'd200, 16'd7, 17, 32'd28, 16'd4, 1'b0);
        run16("w16_div0", 2'd1, 16'd13, 16'd0, 2, 32'hFFFF_FFFF, 16'd13, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
